wrr_arbiter: RTL and testbench

Weighted round-robin arbiter with runtime-programmable per-requester weights, grant locking until acknowledged, and a selectable plain round-robin mode. It sits in front of shared resources (bus masters, memory ports, output queues), where one requester is served per accepted transfer and bandwidth is split in proportion to software-set weights. It generalises the fixed-weight arbiter by adding:
- weights loaded from a port at each round reload;
- a grant that stays stable until `i_ack`;
- an index output;
- a mode pin.

---
 rtl/wrr_arbiter_pkg.sv | 10 +
 rtl/wrr_arbiter_if.sv | 25 ++
 rtl/rr_priority_picker.sv | 38 +++
 rtl/wrr_arbiter.sv | 116 +++++++++++
 tb/tb_wrr_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wrr_arbiter_pkg.sv
// Shared types for the weighted round-robin arbiter family.
// The mode encoding matches the i_mode pin.
package wrr_arbiter_pkg;

   typedef enum logic {
      WRR_MODE_WEIGHTED = 1'b0,
      WRR_MODE_PLAIN    = 1'b1
   } wrr_mode_e;

endpackage

// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface wrr_arbiter_if #(
   parameter int REQUEST_WIDTH = 4,
   parameter int WEIGHT_WIDTH  = 4
);
   localparam int INDEX_WIDTH = (REQUEST_WIDTH == 1) ? 1 : $clog2(REQUEST_WIDTH);

   logic                                        i_mode;
   logic [REQUEST_WIDTH-1:0][WEIGHT_WIDTH-1:0]  i_weight;
   logic [REQUEST_WIDTH-1:0]                    i_request;
   logic                                        i_ack;
   logic [REQUEST_WIDTH-1:0]                    o_grant;
   logic                                        o_grant_valid;
   logic [INDEX_WIDTH-1:0]                      o_grant_index;

   modport master (
      output i_mode, i_weight, i_request, i_ack,
      input  o_grant, o_grant_valid, o_grant_index
   );

   modport slave (
      input  i_mode, i_weight, i_request, i_ack,
      output o_grant, o_grant_valid, o_grant_index
   );
endinterface

// File: rtl/rr_priority_picker.sv
// Combinational rotate-and-find-first: grants the first eligible bit at or
// above start_index, wrapping upward. Expects start_index < N.
module rr_priority_picker #(
   parameter int N = 4,
   localparam int IW = (N == 1) ? 1 : $clog2(N)
) (
   input  logic [N-1:0]  i_eligible,
   input  logic [IW-1:0] i_start,
   output logic [N-1:0]  o_grant,
   output logic [IW-1:0] o_index,
   output logic          o_found
);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [IW:0]    pos;

   always_comb begin
      doubled = {i_eligible, i_eligible};
      rotated = doubled[i_start +: N];
      pos     = '0;
      o_index = '0;
      o_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (!o_found && rotated[i]) begin
            o_found = 1'b1;
            pos     = {1'b0, i_start} + (IW+1)'(i);
            // Undo the rotation, folding positions past the top back to zero.
            if (pos >= (IW+1)'(N)) begin
               pos = pos - (IW+1)'(N);
            end
            o_index = pos[IW-1:0];
         end
      end
      o_grant = o_found ? (N'(1) << o_index) : '0;
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: per-requester credits reloaded from i_weight,
// grant held until acknowledged, optional plain round-robin mode.
module wrr_arbiter
   import wrr_arbiter_pkg::*;
#(
   parameter int REQUEST_WIDTH = 4,
   parameter int WEIGHT_WIDTH  = 4,
   localparam int N  = REQUEST_WIDTH,
   localparam int WW = WEIGHT_WIDTH,
   localparam int IW = (N == 1) ? 1 : $clog2(N)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   wrr_arbiter_if.slave  bus
);

   logic [N-1:0][WW-1:0] credit_q, credit_d;
   logic [IW-1:0]        last_q, last_d;
   logic                 lock_q, lock_d;
   logic [IW-1:0]        lock_idx_q, lock_idx_d;

   logic                 weighted;
   logic                 reload;
   logic [N-1:0][WW-1:0] eff_weight;
   logic [N-1:0][WW-1:0] credit_eff;
   logic [N-1:0]         credit_ok;
   logic [N-1:0]         eligible;
   logic [IW-1:0]        start_idx;
   logic [N-1:0]         pick_grant;
   logic [IW-1:0]        pick_index;
   logic                 pick_found;
   logic                 lock_hold;
   logic [N-1:0]         grant;
   logic [IW-1:0]        grant_index;
   logic                 grant_valid;

   // A reload substitutes the weights for the credits in the same cycle, so
   // arbitration never stalls waiting for new credits.
   always_comb begin
      weighted = (wrr_mode_e'(bus.i_mode) == WRR_MODE_WEIGHTED);
      for (int i = 0; i < N; i++) begin
         eff_weight[i] = (bus.i_weight[i] == '0) ? WW'(1) : bus.i_weight[i];
         credit_ok[i]  = (credit_q[i] != '0);
      end
      reload     = weighted && (|bus.i_request) && !(|(bus.i_request & credit_ok));
      credit_eff = reload ? eff_weight : credit_q;
      for (int i = 0; i < N; i++) begin
         eligible[i] = bus.i_request[i] && (!weighted || (credit_eff[i] != '0));
      end
   end

   assign start_idx = (last_q == IW'(N-1)) ? '0 : last_q + 1'b1;

   rr_priority_picker #(.N(N)) u_picker (
      .i_eligible (eligible),
      .i_start    (start_idx),
      .o_grant    (pick_grant),
      .o_index    (pick_index),
      .o_found    (pick_found)
   );

   // An unacknowledged grant is held only while its requester still asks.
   always_comb begin
      lock_hold = lock_q && bus.i_request[lock_idx_q];
      if (lock_hold) begin
         grant       = N'(1) << lock_idx_q;
         grant_index = lock_idx_q;
         grant_valid = 1'b1;
      end else begin
         grant       = pick_grant;
         grant_index = pick_found ? pick_index : '0;
         grant_valid = pick_found;
      end
   end

   assign bus.o_grant       = grant;
   assign bus.o_grant_valid = grant_valid;
   assign bus.o_grant_index = grant_index;

   always_comb begin
      credit_d   = weighted ? credit_eff : credit_q;
      last_d     = last_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      if (grant_valid) begin
         if (bus.i_ack) begin
            last_d = grant_index;
            lock_d = 1'b0;
            if (weighted) begin
               credit_d[grant_index] = (credit_eff[grant_index] != '0)
                                       ? credit_eff[grant_index] - WW'(1) : '0;
            end
         end else begin
            lock_d     = 1'b1;
            lock_idx_d = grant_index;
         end
      end
   end

   // Zero credits force a reload on the first request; last = N-1 gives
   // requester 0 first priority out of reset.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         credit_q   <= '0;
         last_q     <= IW'(N-1);
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         credit_q   <= credit_d;
         last_q     <= last_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
      end
   end

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed and randomized checks of wrr_arbiter against a behavioural
// model of credits, round-robin pointer and grant lock.
module tb_wrr_arbiter;

   localparam int N  = 4;
   localparam int WW = 4;

   logic i_clk;
   logic i_rst_n;

   int checks;
   int errors;

   wrr_arbiter_if #(.REQUEST_WIDTH(N), .WEIGHT_WIDTH(WW)) bus ();

   wrr_arbiter #(.REQUEST_WIDTH(N), .WEIGHT_WIDTH(WW)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Model state and the per-cycle evaluation result.
   int m_credit [N];
   int m_last;
   bit m_lock;
   int m_lock_idx;
   int e_credit [N];
   int e_idx;

   function automatic int weightOf(int i);
      int w;
      w = int'(bus.i_weight[i]);
      return (w == 0) ? 1 : w;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < N; i++) m_credit[i] = 0;
      m_last = N - 1;
      m_lock = 1'b0;
      m_lock_idx = 0;
   endfunction

   function automatic void modelEval();
      bit weighted;
      bit any_req;
      bit any_elig;
      weighted = (bus.i_mode == 1'b0);
      any_req  = 1'b0;
      any_elig = 1'b0;
      for (int i = 0; i < N; i++) begin
         e_credit[i] = m_credit[i];
         if (bus.i_request[i]) begin
            any_req = 1'b1;
            if (m_credit[i] > 0) any_elig = 1'b1;
         end
      end
      if (weighted && any_req && !any_elig) begin
         for (int i = 0; i < N; i++) e_credit[i] = weightOf(i);
      end
      e_idx = -1;
      if (m_lock && bus.i_request[m_lock_idx]) begin
         e_idx = m_lock_idx;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (e_idx < 0 && bus.i_request[j] && (!weighted || e_credit[j] > 0)) e_idx = j;
         end
      end
   endfunction

   function automatic void modelCommit();
      bit weighted;
      weighted = (bus.i_mode == 1'b0);
      if (weighted) begin
         for (int i = 0; i < N; i++) m_credit[i] = e_credit[i];
      end
      if (e_idx >= 0) begin
         if (bus.i_ack) begin
            m_last = e_idx;
            m_lock = 1'b0;
            if (weighted && m_credit[e_idx] > 0) m_credit[e_idx]--;
         end else begin
            m_lock = 1'b1;
            m_lock_idx = e_idx;
         end
      end
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Compare all three outputs with the model's view of this cycle.
   task automatic checkOutput(input string tag);
      logic [N-1:0] exp_grant;
      modelEval();
      exp_grant = (e_idx >= 0) ? (N'(1) << e_idx) : '0;
      checkValue({tag, ".grant"}, 32'(bus.o_grant), 32'(exp_grant));
      checkValue({tag, ".valid"}, 32'(bus.o_grant_valid), 32'(e_idx >= 0));
      checkValue({tag, ".index"}, 32'(bus.o_grant_index), (e_idx >= 0) ? 32'(e_idx) : 32'd0);
   endtask

   task automatic applyStimulus(input logic [N-1:0] req, input logic mode, input logic ack);
      bus.i_request = req;
      bus.i_mode    = mode;
      bus.i_ack     = ack;
      #1;
   endtask

   task automatic setWeights(input int w0, input int w1, input int w2, input int w3);
      bus.i_weight[0] = WW'(w0);
      bus.i_weight[1] = WW'(w1);
      bus.i_weight[2] = WW'(w2);
      bus.i_weight[3] = WW'(w3);
   endtask

   task automatic tick();
      modelEval();
      @(posedge i_clk);
      modelCommit();
      #1;
   endtask

   task automatic doReset();
      i_rst_n = 1'b0;
      modelReset();
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      #1;
   endtask

   int share_seq [10] = '{0, 1, 2, 3, 1, 2, 3, 2, 3, 3};
   int plain_seq [5]  = '{0, 1, 2, 3, 0};

   initial begin
      checks = 0;
      errors = 0;
      bus.i_request = '0;
      bus.i_mode    = 1'b0;
      bus.i_ack     = 1'b0;
      setWeights(1, 2, 3, 4);
      i_rst_n = 1'b1;
      #2;
      doReset();

      // Idle after reset.
      applyStimulus(4'b0000, 1'b0, 1'b1);
      checkValue("reset.grant", 32'(bus.o_grant), 32'd0);
      checkValue("reset.valid", 32'(bus.o_grant_valid), 32'd0);
      checkOutput("reset");
      tick();

      // Proportional share: two full rounds.
      doReset();
      for (int r = 0; r < 20; r++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         checkValue("share.seq", 32'(bus.o_grant_index), 32'(share_seq[r % 10]));
         checkOutput("share");
         tick();
      end

      // Lock: grant 0 held for 5 unacked cycles, then acked.
      doReset();
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b0011, 1'b0, (c == 5));
         checkValue("lock.hold", 32'(bus.o_grant), 32'h1);
         checkOutput("lock");
         tick();
      end
      applyStimulus(4'b0011, 1'b0, 1'b1);
      checkValue("lock.next", 32'(bus.o_grant), 32'h2);
      checkOutput("lock.after");
      tick();

      // Withdraw: lock on 2, then 2 drops its request.
      doReset();
      applyStimulus(4'b0100, 1'b0, 1'b0);
      checkValue("withdraw.lock", 32'(bus.o_grant_index), 32'd2);
      tick();
      applyStimulus(4'b1011, 1'b0, 1'b1);
      checkValue("withdraw.move", 32'(bus.o_grant_index), 32'd0);
      checkOutput("withdraw");
      tick();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         checkOutput("withdraw.cont");
         tick();
      end

      // Zero weights: the lone requester is reloaded every grant.
      doReset();
      setWeights(0, 0, 5, 0);
      for (int c = 0; c < 6; c++) begin
         applyStimulus(4'b0010, 1'b0, 1'b1);
         checkValue("zero.grant", 32'(bus.o_grant), 32'h2);
         checkOutput("zero");
         tick();
      end

      // Plain mode, then return to weighted with frozen credits.
      doReset();
      setWeights(1, 1, 1, 8);
      for (int c = 0; c < 5; c++) begin
         applyStimulus(4'b1111, 1'b1, 1'b1);
         checkValue("plain.seq", 32'(bus.o_grant_index), 32'(plain_seq[c]));
         checkOutput("plain");
         tick();
      end
      for (int c = 0; c < 3; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         checkOutput("mode.w1");
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         applyStimulus(4'b1111, 1'b1, 1'b1);
         checkOutput("mode.p");
         tick();
      end
      for (int c = 0; c < 8; c++) begin
         applyStimulus(4'b1111, 1'b0, 1'b1);
         checkOutput("mode.w2");
         tick();
      end

      // Reset asserted while locked on 3.
      doReset();
      setWeights(1, 2, 3, 4);
      applyStimulus(4'b1000, 1'b0, 1'b0);
      tick();
      applyStimulus(4'b1111, 1'b0, 1'b0);
      checkValue("rstlock.locked", 32'(bus.o_grant_index), 32'd3);
      i_rst_n = 1'b0;
      modelReset();
      #1;
      checkValue("rstlock.during", 32'(bus.o_grant_index), 32'd0);
      checkOutput("rstlock.during");
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      applyStimulus(4'b1111, 1'b0, 1'b1);
      checkValue("rstlock.first", 32'(bus.o_grant_index), 32'd0);
      checkOutput("rstlock.first");
      tick();

      // Randomized traffic against the model.
      doReset();
      for (int c = 0; c < 600; c++) begin
         if (c % 50 == 0) begin
            setWeights(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
         end
         applyStimulus(N'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
         checkOutput("random");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
